// File: rtl/ysyx_22040759_if.sv
// Instruction fetch stage: one outstanding fetch, holds the fetched instruction
// until decode accepts it, and squashes in-flight fetches on branch redirect.
module ysyx_22040759_if #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ds_allowin,
    input  logic [64:0] bru_to_fs_bus,
    output logic        inst_req_valid,
    input  logic        inst_req_ready,
    output logic [63:0] inst_req_addr,
    input  logic        inst_resp_valid,
    input  logic [31:0] inst_resp_data,
    output logic        fs_to_ds_valid,
    output logic [95:0] fs_to_ds_bus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state;
    logic [63:0] fetch_pc;
    logic [63:0] tgt_pc;
    logic        discard;
    logic [31:0] inst_r;

    logic        br_taken;
    logic [63:0] br_target;

    assign br_taken  = bru_to_fs_bus[64];
    assign br_target = bru_to_fs_bus[63:0] & ~64'h3;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            tgt_pc   <= RESET_PC;
            discard  <= 1'b0;
            inst_r   <= 32'h0000_0013;
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                    if (br_taken) fetch_pc <= br_target;
                end
                REQ: begin
                    // The presented address must not change; the target waits
                    // until the doomed fetch has returned.
                    if (br_taken) begin
                        tgt_pc  <= br_target;
                        discard <= 1'b1;
                    end
                    if (inst_req_ready) state <= WAIT;
                end
                WAIT: begin
                    if (inst_resp_valid) begin
                        if (discard || br_taken) begin
                            discard  <= 1'b0;
                            fetch_pc <= br_taken ? br_target : tgt_pc;
                            state    <= REQ;
                        end else begin
                            inst_r <= inst_resp_data;
                            state  <= HOLD;
                        end
                    end else if (br_taken) begin
                        tgt_pc  <= br_target;
                        discard <= 1'b1;
                    end
                end
                HOLD: begin
                    if (br_taken) begin
                        fetch_pc <= br_target;
                        state    <= REQ;
                    end else if (ds_allowin) begin
                        fetch_pc <= fetch_pc + 64'd4;
                        state    <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The decode handshake is masked combinationally so a redirect kills the
    // held instruction in the very cycle it arrives.
    assign inst_req_valid = (state == REQ);
    assign inst_req_addr  = fetch_pc;
    assign fs_to_ds_valid = (state == HOLD) && !br_taken;
    assign fs_to_ds_bus   = {inst_r, fetch_pc};

endmodule

// File: tb/tb_ysyx_22040759_if.sv
// Bench for the fetch stage: directed protocol scenarios, then random traffic
// checked against a program-order model of which (pc, inst) pairs reach decode.
module tb_ysyx_22040759_if;
    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ds_allowin;
    logic [64:0] bru_to_fs_bus;
    logic        inst_req_valid;
    logic        inst_req_ready;
    logic [63:0] inst_req_addr;
    logic        inst_resp_valid;
    logic [31:0] inst_resp_data;
    logic        fs_to_ds_valid;
    logic [95:0] fs_to_ds_bus;

    int n_chk  = 0;
    int n_fail = 0;

    // memory / program-order model state
    logic        pend;
    logic [63:0] pend_addr;
    int          dly;
    logic        prev_stall;
    logic [63:0] prev_addr;
    logic [63:0] exp_pc;
    int          xfers, accepted, redirects;

    always #5 clk = ~clk;

    ysyx_22040759_if #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .ds_allowin     (ds_allowin),
        .bru_to_fs_bus  (bru_to_fs_bus),
        .inst_req_valid (inst_req_valid),
        .inst_req_ready (inst_req_ready),
        .inst_req_addr  (inst_req_addr),
        .inst_resp_valid(inst_resp_valid),
        .inst_resp_data (inst_resp_data),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'hA5A5_0013;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        ds_allowin      = 1'b0;
        bru_to_fs_bus   = '0;
        inst_req_ready  = 1'b0;
        inst_resp_valid = 1'b0;
        inst_resp_data  = '0;
    endtask

    task automatic redirect(input logic [63:0] tgt);
        bru_to_fs_bus = {1'b1, tgt};
    endtask

    task automatic chk_req(input string tag, input logic [63:0] addr);
        chk({tag, "_valid"}, 128'(inst_req_valid), 128'(1));
        chk({tag, "_addr"}, 128'(inst_req_addr), 128'(addr));
    endtask

    // One cycle of random traffic: memory responder + scoreboard of decode order.
    task automatic cycle(input logic al, input logic rdy, input logic br, input logic [63:0] tgt);
        ds_allowin      = al;
        inst_req_ready  = rdy;
        bru_to_fs_bus   = {br, tgt};
        inst_resp_valid = 1'b0;
        if (pend) begin
            if (dly == 0) begin
                inst_resp_valid = 1'b1;
                inst_resp_data  = mem_word(pend_addr);
            end else begin
                dly--;
            end
        end
        #1;
        if (br) chk("r_br_suppress", 128'(fs_to_ds_valid), 128'(0));
        if (pend) chk("r_one_outstanding", 128'(inst_req_valid), 128'(0));
        if (inst_req_valid) begin
            chk("r_addr_align", 128'(inst_req_addr[1:0]), 128'(0));
            if (prev_stall) chk("r_addr_stable", 128'(inst_req_addr), 128'(prev_addr));
        end
        prev_stall = inst_req_valid && !rdy;
        prev_addr  = inst_req_addr;
        if (inst_resp_valid) pend = 1'b0;
        if (inst_req_valid && rdy) begin
            pend      = 1'b1;
            pend_addr = inst_req_addr;
            dly       = $urandom_range(0, 2);
            accepted++;
        end
        if (fs_to_ds_valid && al) begin
            chk("r_pc", 128'(fs_to_ds_bus[63:0]), 128'(exp_pc));
            chk("r_inst", 128'(fs_to_ds_bus[95:64]), 128'(mem_word(exp_pc)));
            exp_pc = exp_pc + 64'd4;
            xfers++;
        end
        if (br) begin
            exp_pc = tgt & ~64'h3;
            redirects++;
        end
        tick;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        idle_in;
        rst = 1'b0;
        tick;
        tick;
        chk("rst_req_valid", 128'(inst_req_valid), 128'(0));
        chk("rst_fs_valid", 128'(fs_to_ds_valid), 128'(0));
        chk("rst_bus", 128'(fs_to_ds_bus), 128'({32'h13, RST_PC}));

        // basic fetch: IDLE for one cycle, then request, response, transfer
        rst = 1'b1;
        #1;
        chk("idle_req_valid", 128'(inst_req_valid), 128'(0));
        tick;
        chk_req("t1_req", RST_PC);
        inst_req_ready = 1'b1;
        ds_allowin     = 1'b1;
        tick;
        chk("t1_wait_valid", 128'(inst_req_valid), 128'(0));
        inst_resp_valid = 1'b1;
        inst_resp_data  = 32'h0000_0513;
        tick;
        inst_resp_valid = 1'b0;
        chk("t1_fs_valid", 128'(fs_to_ds_valid), 128'(1));
        chk("t1_fs_bus", 128'(fs_to_ds_bus), 128'({32'h0000_0513, RST_PC}));
        tick;
        chk("t1_after_fs", 128'(fs_to_ds_valid), 128'(0));
        chk_req("t1_next", RST_PC + 64'd4);

        // decode back-pressure in HOLD
        ds_allowin = 1'b0;
        tick;
        inst_resp_valid = 1'b1;
        inst_resp_data  = 32'h0010_0093;
        tick;
        inst_resp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", 128'(fs_to_ds_valid), 128'(1));
            chk("t2_hold_bus", 128'(fs_to_ds_bus), 128'({32'h0010_0093, RST_PC + 64'd4}));
            chk("t2_no_req", 128'(inst_req_valid), 128'(0));
            tick;
        end
        ds_allowin = 1'b1;
        chk("t2_release", 128'(fs_to_ds_valid), 128'(1));
        tick;
        chk("t2_one_xfer", 128'(fs_to_ds_valid), 128'(0));
        chk_req("t2_next", RST_PC + 64'd8);

        // redirect while waiting for the response
        tick;
        redirect(64'h8000_0100);
        #1;
        chk("t3_br_fs", 128'(fs_to_ds_valid), 128'(0));
        tick;
        bru_to_fs_bus   = '0;
        inst_resp_valid = 1'b1;
        inst_resp_data  = 32'hDEAD_BEEF;
        #1;
        chk("t3_resp_fs", 128'(fs_to_ds_valid), 128'(0));
        tick;
        inst_resp_valid = 1'b0;
        chk("t3_after_fs", 128'(fs_to_ds_valid), 128'(0));
        chk_req("t3_next", 64'h8000_0100);

        // redirect in HOLD with decode ready: transfer suppressed, target aligned
        tick;
        inst_resp_valid = 1'b1;
        inst_resp_data  = 32'h0000_0113;
        tick;
        inst_resp_valid = 1'b0;
        redirect(64'h8000_0203);
        #1;
        chk("t4_suppress", 128'(fs_to_ds_valid), 128'(0));
        tick;
        bru_to_fs_bus = '0;
        chk("t4_after_fs", 128'(fs_to_ds_valid), 128'(0));
        chk_req("t4_next", 64'h8000_0200);

        // redirect coinciding with the response
        tick;
        inst_resp_valid = 1'b1;
        inst_resp_data  = 32'h0000_0193;
        redirect(64'h8000_0300);
        #1;
        chk("t5_fs", 128'(fs_to_ds_valid), 128'(0));
        tick;
        inst_resp_valid = 1'b0;
        bru_to_fs_bus   = '0;
        chk("t5_after_fs", 128'(fs_to_ds_valid), 128'(0));
        chk_req("t5_next", 64'h8000_0300);

        // two redirects while waiting: last one wins
        tick;
        redirect(64'h8000_0400);
        tick;
        redirect(64'h8000_0480);
        tick;
        bru_to_fs_bus   = '0;
        inst_resp_valid = 1'b1;
        inst_resp_data  = 32'h0000_0213;
        tick;
        inst_resp_valid = 1'b0;
        chk("t6_fs", 128'(fs_to_ds_valid), 128'(0));
        chk_req("t6_next", 64'h8000_0480);

        // redirect during a stalled request
        idle_in;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) redirect(64'h8000_0040);
            else bru_to_fs_bus = '0;
            #1;
            chk_req("t7_stall", RST_PC);
            tick;
        end
        bru_to_fs_bus  = '0;
        inst_req_ready = 1'b1;
        chk_req("t7_accept", RST_PC);
        tick;
        inst_req_ready  = 1'b0;
        inst_resp_valid = 1'b1;
        inst_resp_data  = 32'h0000_0293;
        #1;
        chk("t7_resp_fs", 128'(fs_to_ds_valid), 128'(0));
        tick;
        inst_resp_valid = 1'b0;
        chk("t7_after_fs", 128'(fs_to_ds_valid), 128'(0));
        chk_req("t7_next", 64'h8000_0040);

        // reset during WAIT, stale response afterwards
        inst_req_ready = 1'b1;
        tick;
        inst_req_ready = 1'b0;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        inst_resp_valid = 1'b1;
        inst_resp_data  = 32'h0000_0BAD;
        #1;
        chk("t8_idle_req", 128'(inst_req_valid), 128'(0));
        tick;
        inst_resp_valid = 1'b0;
        chk("t8_fs", 128'(fs_to_ds_valid), 128'(0));
        chk_req("t8_restart", RST_PC);
        inst_req_ready = 1'b1;
        tick;
        inst_req_ready  = 1'b0;
        inst_resp_valid = 1'b1;
        inst_resp_data  = 32'h0000_0393;
        tick;
        inst_resp_valid = 1'b0;
        chk("t8_fs_valid", 128'(fs_to_ds_valid), 128'(1));
        chk("t8_fs_bus", 128'(fs_to_ds_bus), 128'({32'h0000_0393, RST_PC}));

        // redirect in IDLE replaces the reset PC
        idle_in;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        redirect(64'h8000_0500);
        tick;
        bru_to_fs_bus = '0;
        chk_req("t9_first", 64'h8000_0500);

        // random traffic
        idle_in;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        pend = 1'b0;
        dly = 0;
        prev_stall = 1'b0;
        prev_addr = '0;
        exp_pc = RST_PC;
        xfers = 0;
        accepted = 0;
        redirects = 0;
        for (int c = 0; c < 3000; c++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0,
                  64'h8000_0000 + 64'($urandom_range(0, 1023)));
        end
        chk("r_progress", 128'(xfers > 100), 128'(1));
        chk("r_no_loss", 128'((accepted >= xfers) && (accepted - xfers <= redirects + 1)), 128'(1));

        // drain: with no redirects and everything ready, decode must see the next pc
        got = xfers;
        for (int c = 0; c < 30 && xfers == got; c++) cycle(1'b1, 1'b1, 1'b0, '0);
        chk("drain_xfer", 128'(xfers - got), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
